// File: rtl/edge_detector_bank.sv
// edge_detector_bank: per-channel input synchroniser, debouncer and qualified edge-event detector
// Ports:
//   clk            rising-edge clock for all state
//   async_reset    active-low asynchronous reset; release must be synchronous to clk
//   signal_input   raw asynchronous inputs, one bit per channel
//   edge_mode      two bits per channel: bit 0 enables rising, bit 1 enables falling events
//   event_clear    per-channel clear of event_pending (a simultaneous new event wins)
//   signal_level   debounced level per channel
//   signal_output  one-cycle pulse after a qualified debounced level change
//   event_pending  sticky per-channel flag set by each pulse
module edge_detector_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic [CHANNELS-1:0]   signal_input,
    input  logic [2*CHANNELS-1:0] edge_mode,
    input  logic [CHANNELS-1:0]   event_clear,
    output logic [CHANNELS-1:0]   signal_level,
    output logic [CHANNELS-1:0]   signal_output,
    output logic [CHANNELS-1:0]   event_pending
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d, pulse_q, pulse_d, pend_q, pend_d;
    logic [CHANNELS-1:0]                  sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], signal_input};
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // The counter only runs while the synchronised input disagrees with the accepted level;
            // any agreeing sample restarts the stability window.
            if (sync[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync[i];
                    pulse_d[i] = sync[i] ? edge_mode[2*i] : edge_mode[2*i+1];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        pend_d = pulse_d | (pend_q & ~event_clear);
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
            pend_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
        end
    end

    assign signal_level  = level_q;
    assign signal_output = pulse_q;
    assign event_pending = pend_q;
endmodule

// File: doc/edge_detector_bank.md
EDGE_DETECTOR_BANK -- requirements
Module: edge_detector_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels (1..32).
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flip-flops per channel (>=2).
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised samples required to accept a level change (>=1); counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)), minimum 1.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port async_reset  input  1  reset, asynchronous assert, active-low.
REQ-006 Port signal_input  input  CHANNELS  raw asynchronous inputs (buttons/switches).
REQ-007 Port edge_mode  input  2*CHANNELS  per channel i, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 Port event_clear  input  CHANNELS  synchronous clear of event_pending[i].
REQ-009 Port signal_level  output  CHANNELS  debounced level, registered.
REQ-010 Port signal_output  output  CHANNELS  one-cycle edge pulse, registered.
REQ-011 Port event_pending  output  CHANNELS  sticky edge flag, registered.

Function
REQ-012 Each channel SHALL be independent; no cross-channel interaction.
REQ-013 Synchroniser: stage 1 samples signal_input[i]; stage n samples stage n-1; sync[i] = last stage.
REQ-014 Debounce: if sync[i] == signal_level[i], counter[i] SHALL load 0.
REQ-015 If sync[i] != signal_level[i] and counter[i] < DEBOUNCE_CYCLES-1, counter[i] SHALL increment.
REQ-016 If sync[i] != signal_level[i] and counter[i] == DEBOUNCE_CYCLES-1, signal_level[i] SHALL take sync[i] and counter[i] SHALL load 0 on that edge.
REQ-017 A sync[i] excursion lasting fewer than DEBOUNCE_CYCLES cycles SHALL NOT change signal_level[i] and SHALL NOT produce a pulse.
REQ-018 Latency: input change first captured at edge k -> signal_level and signal_output update at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
REQ-019 signal_output[i] SHALL be 1 for exactly the one cycle following the edge at which signal_level[i] changes, if qualified by edge_mode: 0->1 needs mode bit 0 set, 1->0 needs mode bit 1 set; otherwise 0.
REQ-020 edge_mode SHALL be sampled on the same edge at which signal_level changes; mode changes never create or cancel pulses retroactively.
REQ-021 edge_mode = 00 SHALL suppress pulses and events; signal_level still tracks the input.
REQ-022 event_pending[i] SHALL set on the edge at which signal_output[i] is set, and clear on an edge where event_clear[i] = 1.
REQ-023 Simultaneous set and event_clear on the same channel: set SHALL win (event_pending stays 1).
REQ-024 event_pending SHALL NOT count; repeated edges before a clear leave it at 1.
REQ-025 Two qualified changes on one channel are at least DEBOUNCE_CYCLES cycles apart; pulses SHALL never be back-to-back when DEBOUNCE_CYCLES > 1.

Reset
REQ-026 async_reset = 0 SHALL immediately clear all synchroniser stages, counters, signal_level, signal_output and event_pending to 0, regardless of clk.
REQ-027 Reset mid-debounce SHALL discard the count; no pulse is produced for that in-progress change.
REQ-028 An input held high through reset release SHALL be treated as a 0->1 change and SHALL produce a rising pulse (if enabled) after the REQ-018 latency.
REQ-029 Release of async_reset SHALL be synchronous to clk externally; the block does not synchronise its own reset.

Verification
REQ-030 Defaults, mode 01, ch0 input 0->1 captured at edge 10 -> signal_level[0] = 1 and signal_output[0] = 1 after edge 15 only; event_pending[0] = 1 from edge 15.
REQ-031 Defaults, ch1 input high for 2 cycles, then low -> signal_level[1], signal_output[1] and event_pending[1] stay 0.
REQ-032 Mode 11 on ch2, clean high then low pulse 20 cycles wide -> two single-cycle pulses 20 cycles apart; mode 10 -> only the falling-edge pulse.
REQ-033 event_clear[0] = 1 on the same edge as a new ch0 pulse -> event_pending[0] remains 1; event_clear[0] on a later edge -> 0 on the next cycle.
REQ-034 async_reset asserted between clk edges while ch3 is counting -> all outputs 0 immediately; release with input low -> no pulse.
REQ-035 DEBOUNCE_CYCLES=1, SYNC_STAGES=3, CHANNELS=1: step captured at edge 5 -> pulse after edge 8.
